// File: rtl/cache_miss_arb.sv
// Round-robin arbiter funnelling cache-miss packets from NUM_REQ controllers into
// one registered downstream queue, routing in-order acks back to each packet's issuer.
module cache_miss_arb #(
    parameter int NUM_REQ         = 2,
    parameter int PKT_WIDTH       = 37,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_vld_i,
    output logic [NUM_REQ-1:0]           req_rdy_o,
    input  logic [NUM_REQ*PKT_WIDTH-1:0] req_dat_i,
    output logic [NUM_REQ-1:0]           req_ack_o,
    output logic                         qvld_o,
    input  logic                         qrdy_i,
    output logic [PKT_WIDTH-1:0]         qdat_o,
    input  logic                         ack_i,
    output logic                         busy_o,
    output logic                         err_o
);
    localparam int TW = $clog2(NUM_REQ);
    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int CW = PW + 1;

    logic                 r_qvld;
    logic [PKT_WIDTH-1:0] r_qdat;
    logic [TW-1:0]        r_tag;
    logic [TW-1:0]        r_ptr;
    logic [TW-1:0]        r_own [MAX_OUTSTANDING];
    logic [PW-1:0]        r_wp;
    logic [PW-1:0]        r_rp;
    logic [CW-1:0]        r_cnt;
    logic [NUM_REQ-1:0]   r_ack;
    logic                 r_err;

    logic [CW-1:0] w_total;
    logic          w_slot;
    logic          w_qbeat;
    logic          w_pop;
    logic          w_gnt;
    logic [TW-1:0] w_gidx;

    assign w_total = CW'(r_qvld) + r_cnt;
    // An ack this cycle only frees its slot next cycle: the test uses registered state.
    assign w_slot  = (!r_qvld || qrdy_i) && (w_total < CW'(MAX_OUTSTANDING));
    assign w_qbeat = r_qvld && qrdy_i;
    assign w_pop   = ack_i && (r_cnt != '0);

    always_comb begin
        int idx;
        idx    = 0;
        w_gnt  = 1'b0;
        w_gidx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (w_slot && !w_gnt && req_vld_i[idx]) begin
                w_gnt  = 1'b1;
                w_gidx = TW'(idx);
            end
        end
    end

    always_comb begin
        req_rdy_o = '0;
        for (int i = 0; i < NUM_REQ; i++)
            req_rdy_o[i] = w_gnt && (w_gidx == TW'(i));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_qvld <= 1'b0;
            r_qdat <= '0;
            r_tag  <= '0;
            r_ptr  <= '0;
            r_wp   <= '0;
            r_rp   <= '0;
            r_cnt  <= '0;
            r_ack  <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_gnt) begin
                r_qvld <= 1'b1;
                r_qdat <= req_dat_i[w_gidx*PKT_WIDTH +: PKT_WIDTH];
                r_tag  <= w_gidx;
                r_ptr  <= (w_gidx == TW'(NUM_REQ-1)) ? '0 : w_gidx + 1'b1;
            end else if (w_qbeat) begin
                r_qvld <= 1'b0;
            end
            if (w_qbeat) r_wp <= r_wp + 1'b1;
            if (w_pop)   r_rp <= r_rp + 1'b1;
            case ({w_qbeat, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
            r_ack <= '0;
            if (w_pop) r_ack[r_own[r_rp]] <= 1'b1;
            // Covers acks after reset and acks aimed at a packet not yet issued downstream.
            if (ack_i && (r_cnt == '0)) r_err <= 1'b1;
        end
    end

    // Owner tags need no reset; the count and pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (reset && w_qbeat) r_own[r_wp] <= r_tag;
    end

    assign qvld_o    = r_qvld;
    assign qdat_o    = r_qdat;
    assign req_ack_o = r_ack;
    assign err_o     = r_err;
    assign busy_o    = r_qvld || (r_cnt != '0);
endmodule
